// File: rtl/control_unit.sv
// Hardwired control sequencer: steps RESET/T0-T7/PAUSE/HALT and
// decodes IR[31:27] into the Moore datapath strobes.
// Ports: clock, clear (async active-low), IR, CON_FF, stop -> run + strobes.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MD_read,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Csignout,
  output logic        CONin,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_e;

  state_e state_q, state_d, last_t, to_t0;

  logic [4:0] opc;
  logic is_ld, is_ldi, is_st, is_alu, is_imm;
  logic is_br, is_jr, is_halt;
  logic op_add, op_sub, op_and, op_or;
  logic unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];

  assign is_ld   = (opc == 5'b00000);
  assign is_ldi  = (opc == 5'b00001);
  assign is_st   = (opc == 5'b00010);
  assign is_alu  = (opc >= 5'b00011) && (opc <= 5'b00110);
  assign is_imm  = (opc >= 5'b01100) && (opc <= 5'b01110);
  assign is_br   = (opc == 5'b10010);
  assign is_jr   = (opc == 5'b10011);
  assign is_halt = (opc == 5'b11011);

  assign op_add = (opc == 5'b00011) || (opc == 5'b01100);
  assign op_sub = (opc == 5'b00100);
  assign op_and = (opc == 5'b00101) || (opc == 5'b01101);
  assign op_or  = (opc == 5'b00110) || (opc == 5'b01110);

  // Final state of each opcode; nop/undefined finish at T2.
  always_comb begin
    last_t = S_T2;
    unique case (1'b1)
      is_ld, is_st:            last_t = S_T7;
      is_ldi, is_alu, is_imm:  last_t = S_T5;
      is_br:                   last_t = S_T6;
      is_jr:                   last_t = S_T3;
      default:                 last_t = S_T2;
    endcase
  end

  // Every return to T0 is diverted to PAUSE while stop is held.
  assign to_t0 = stop ? S_PAUSE : S_T0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_PAUSE: state_d = stop ? S_PAUSE : S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        if (is_halt)             state_d = S_HALT;
        else if (last_t == S_T2) state_d = to_t0;
        else                     state_d = S_T3;
      end
      default: begin
        if (state_q == last_t) state_d = to_t0;
        else state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  always_comb begin
    run = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    MD_read = 1'b0; Read = 1'b0; Write = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0;
    Zhighin = 1'b0; Zlowout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Csignout = 1'b0; CONin = 1'b0;
    ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
    unique case (state_q)
      S_T0: begin
        run = 1'b1;
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; Zlowin = 1'b1;
      end
      S_T1: begin
        run = 1'b1;
        Zlowout = 1'b1; PCin = 1'b1;
        Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1;
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        unique case (1'b1)
          is_ld, is_ldi, is_st: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
          end
          is_alu, is_imm: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          end
          is_br: begin
            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
          end
          is_jr: begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        run = 1'b1;
        unique case (1'b1)
          is_ld, is_ldi, is_st: begin
            Csignout = 1'b1; ADD = 1'b1; Zlowin = 1'b1;
          end
          is_alu, is_imm: begin
            Grc = is_alu; Rout = is_alu;
            Csignout = is_imm;
            ADD = op_add; SUB = op_sub;
            AND = op_and; OR = op_or;
            Zlowin = 1'b1;
          end
          is_br: begin
            PCout = 1'b1; Yin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        unique case (1'b1)
          is_ld, is_st: begin
            Zlowout = 1'b1; MARin = 1'b1;
          end
          is_ldi, is_alu, is_imm: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_br: begin
            Csignout = 1'b1; ADD = 1'b1; Zlowin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        run = 1'b1;
        unique case (1'b1)
          is_ld: begin
            Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1;
          end
          is_st: begin
            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          end
          is_br: begin
            Zlowout = 1'b1; PCin = CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        run = 1'b1;
        unique case (1'b1)
          is_ld: begin
            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_st:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class,
// stop/PAUSE, HALT and async clear against hand-built strobe tables.
module tb_control_unit;

  logic        clock, clear, CON_FF, stop;
  logic [31:0] IR;
  logic run;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, Read;
  logic Write, IRin, Yin, Zlowin, Zhighin, Zlowout, Gra, Grb, Grc;
  logic Rin, Rout, BAout, Csignout, CONin, ADD, SUB, AND, OR;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
    .stop(stop), .run(run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .MD_read(MD_read),
    .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Csignout(Csignout), .CONin(CONin),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR)
  );

  localparam logic [25:0] B_PCout    = 26'h1 << 25;
  localparam logic [25:0] B_PCin     = 26'h1 << 24;
  localparam logic [25:0] B_IncPC    = 26'h1 << 23;
  localparam logic [25:0] B_MARin    = 26'h1 << 22;
  localparam logic [25:0] B_MDRin    = 26'h1 << 21;
  localparam logic [25:0] B_MDRout   = 26'h1 << 20;
  localparam logic [25:0] B_MD_read  = 26'h1 << 19;
  localparam logic [25:0] B_Read     = 26'h1 << 18;
  localparam logic [25:0] B_Write    = 26'h1 << 17;
  localparam logic [25:0] B_IRin     = 26'h1 << 16;
  localparam logic [25:0] B_Yin      = 26'h1 << 15;
  localparam logic [25:0] B_Zlowin   = 26'h1 << 14;
  localparam logic [25:0] B_Zlowout  = 26'h1 << 12;
  localparam logic [25:0] B_Gra      = 26'h1 << 11;
  localparam logic [25:0] B_Grb      = 26'h1 << 10;
  localparam logic [25:0] B_Grc      = 26'h1 << 9;
  localparam logic [25:0] B_Rin      = 26'h1 << 8;
  localparam logic [25:0] B_Rout     = 26'h1 << 7;
  localparam logic [25:0] B_BAout    = 26'h1 << 6;
  localparam logic [25:0] B_Csignout = 26'h1 << 5;
  localparam logic [25:0] B_CONin    = 26'h1 << 4;
  localparam logic [25:0] B_ADD      = 26'h1 << 3;
  localparam logic [25:0] B_AND      = 26'h1 << 1;
  localparam logic [25:0] B_OR       = 26'h1 << 0;

  localparam logic [25:0] F0 = B_PCout | B_MARin | B_IncPC | B_Zlowin;
  localparam logic [25:0] F1 = B_Zlowout | B_PCin | B_Read
                             | B_MD_read | B_MDRin;
  localparam logic [25:0] F2 = B_MDRout | B_IRin;
  localparam logic [25:0] Z  = 26'd0;

  localparam logic [25:0] A3 = B_Grb | B_BAout | B_Yin;
  localparam logic [25:0] A4 = B_Csignout | B_ADD | B_Zlowin;
  localparam logic [25:0] WB = B_Zlowout | B_Gra | B_Rin;
  localparam logic [25:0] R3 = B_Grb | B_Rout | B_Yin;

  logic [25:0] strb;
  assign strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read,
                 Read, Write, IRin, Yin, Zlowin, Zhighin, Zlowout,
                 Gra, Grb, Grc, Rin, Rout, BAout, Csignout, CONin,
                 ADD, SUB, AND, OR};

  logic [25:0] exp_t [8];
  int n_checks = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Entered at a falling edge while in T0; leaves at the falling
  // edge of the state after the n checked states.
  task automatic exec(input string nm, input logic [4:0] op,
                      input logic con, input int n, input int stop_at);
    IR     = {op, 27'h5A5C3F1};
    CON_FF = con;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) stop = 1'b1;
      chk($sformatf("%s_T%0d", nm, i), 32'(strb), 32'(exp_t[i]));
      chk($sformatf("%s_run%0d", nm, i), 32'(run), 32'd1);
      @(negedge clock);
    end
  endtask

  initial begin
    clear = 1'b0; stop = 1'b0; CON_FF = 1'b0; IR = '0;
    repeat (3) @(negedge clock);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    clear = 1'b1;
    @(negedge clock);

    exp_t = '{F0, F1, F2, A3, A4, WB, Z, Z};
    exec("ldi", 5'b00001, 1'b0, 6, -1);

    exp_t = '{F0, F1, F2, R3,
              B_Grc | B_Rout | B_OR | B_Zlowin, WB, Z, Z};
    exec("or", 5'b00110, 1'b0, 6, -1);

    exp_t = '{F0, F1, F2, A3, A4, B_Zlowout | B_MARin,
              B_Read | B_MD_read | B_MDRin,
              B_MDRout | B_Gra | B_Rin};
    exec("ld", 5'b00000, 1'b0, 8, -1);

    exp_t = '{F0, F1, F2, A3, A4, B_Zlowout | B_MARin,
              B_Gra | B_Rout | B_MDRin, B_Write};
    exec("st", 5'b00010, 1'b0, 8, -1);

    exp_t = '{F0, F1, F2, B_Gra | B_Rout | B_CONin,
              B_PCout | B_Yin, A4, B_Zlowout | B_PCin, Z};
    exec("br1", 5'b10010, 1'b1, 7, -1);

    exp_t = '{F0, F1, F2, B_Gra | B_Rout | B_CONin,
              B_PCout | B_Yin, A4, B_Zlowout, Z};
    exec("br0", 5'b10010, 1'b0, 7, -1);

    exp_t = '{F0, F1, F2, B_Gra | B_Rout | B_PCin, Z, Z, Z, Z};
    exec("jr", 5'b10011, 1'b0, 4, -1);

    exp_t = '{F0, F1, F2, Z, Z, Z, Z, Z};
    exec("nop", 5'b11010, 1'b0, 3, -1);
    exec("undef", 5'b11111, 1'b0, 3, -1);

    exp_t = '{F0, F1, F2, R3,
              B_Csignout | B_AND | B_Zlowin, WB, Z, Z};
    exec("andi", 5'b01101, 1'b0, 6, -1);

    // stop raised mid-add: the add finishes, then PAUSE.
    exp_t = '{F0, F1, F2, R3,
              B_Grc | B_Rout | B_ADD | B_Zlowin, WB, Z, Z};
    exec("add", 5'b00011, 1'b0, 6, 3);
    chk("pause_strb", 32'(strb), 32'd0);
    chk("pause_run", 32'(run), 32'd0);
    @(negedge clock);
    chk("pause_hold", 32'(run), 32'd0);
    stop = 1'b0;
    @(negedge clock);
    chk("resume_T0", 32'(strb), 32'(F0));
    chk("resume_run", 32'(run), 32'd1);

    exp_t = '{F0, F1, F2, Z, Z, Z, Z, Z};
    exec("halt", 5'b11011, 1'b0, 3, -1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) stop = 1'b1;
      if (i == 7) stop = 1'b0;
      chk($sformatf("halt_strb%0d", i), 32'(strb), 32'd0);
      chk($sformatf("halt_run%0d", i), 32'(run), 32'd0);
      @(negedge clock);
    end
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("unhalt_T0", 32'(strb), 32'(F0));

    // Asynchronous clear during ld T5.
    exp_t = '{F0, F1, F2, A3, A4, Z, Z, Z};
    exec("ldab", 5'b00000, 1'b0, 5, -1);
    chk("ldab_T5", 32'(strb), 32'(B_Zlowout | B_MARin));
    clear = 1'b0;
    #1;
    chk("abort_strb", 32'(strb), 32'd0);
    chk("abort_run", 32'(run), 32'd0);
    @(negedge clock);
    chk("abort_hold", 32'(strb), 32'd0);
    clear = 1'b1;
    @(negedge clock);
    chk("abort_T0", 32'(strb), 32'(F0));
    @(negedge clock);
    chk("abort_T1", 32'(strb), 32'(F1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
